// File: rtl/pixel_scan_scheduler.sv
// Raster-scan sequencer for the LT24 pixel-write path: fetches colour per pixel,
// holds a write until the driver accepts it, and pulses frame/game ticks between frames.
module pixel_scan_scheduler #(
  parameter int unsigned WIDTH           = 240,
  parameter int unsigned HEIGHT          = 320,
  parameter int unsigned PIPE_LAT        = 1,
  parameter int unsigned FRAMES_PER_TICK = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pixel_ready,
  input  logic [15:0] graphics_rgb,
  output logic [7:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [15:0] pixel_data,
  output logic        pixel_write,
  output logic        frame_done,
  output logic        game_tick,
  output logic [15:0] frame_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, FRAME_END} state_t;

  localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST   = 9'(HEIGHT - 1);
  localparam logic [2:0] LAT_LAST = 3'(PIPE_LAT - 1);
  localparam logic [7:0] DIV_LAST = 8'(FRAMES_PER_TICK - 1);

  state_t      state, state_n;
  logic [2:0]  lat_cnt, lat_n;
  logic [7:0]  div_cnt, div_n;
  logic [7:0]  x_n;
  logic [8:0]  y_n;
  logic [15:0] data_n, count_n;
  logic        write_n, done_n, tick_n;

  always_comb begin
    state_n = state;
    x_n     = pixel_x;
    y_n     = pixel_y;
    data_n  = pixel_data;
    lat_n   = lat_cnt;
    div_n   = div_cnt;
    count_n = frame_count;
    write_n = 1'b0;
    done_n  = 1'b0;
    tick_n  = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_n = FETCH;
          x_n     = '0;
          y_n     = '0;
          lat_n   = '0;
        end
      end
      FETCH: begin
        if (lat_cnt == LAT_LAST) begin
          data_n  = graphics_rgb;
          lat_n   = '0;
          state_n = WRITE;
        end else begin
          lat_n = lat_cnt + 3'd1;
        end
      end
      WRITE: begin
        if (pixel_ready) begin
          if (pixel_x != X_LAST) begin
            x_n     = pixel_x + 8'd1;
            state_n = FETCH;
          end else begin
            x_n = '0;
            if (pixel_y != Y_LAST) begin
              y_n     = pixel_y + 9'd1;
              state_n = FETCH;
            end else begin
              y_n     = '0;
              state_n = FRAME_END;
            end
          end
        end
      end
      FRAME_END: state_n = enable ? FETCH : IDLE;
      default:   state_n = IDLE;
    endcase

    // Moore outputs are registered from the next state so they align with it.
    write_n = (state_n == WRITE);
    if (state_n == FRAME_END) begin
      done_n  = 1'b1;
      count_n = frame_count + 16'd1;
      if (div_cnt == DIV_LAST) begin
        tick_n = 1'b1;
        div_n  = '0;
      end else begin
        div_n = div_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      div_cnt     <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_data  <= '0;
      pixel_write <= 1'b0;
      frame_done  <= 1'b0;
      game_tick   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      lat_cnt     <= lat_n;
      div_cnt     <= div_n;
      pixel_x     <= x_n;
      pixel_y     <= y_n;
      pixel_data  <= data_n;
      pixel_write <= write_n;
      frame_done  <= done_n;
      game_tick   <= tick_n;
      frame_count <= count_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Bench for pixel_scan_scheduler: table-driven frame vectors, directed corner cases,
// and randomized ready/enable/reset traffic checked against a raster-index model.
module tb_pixel_scan_scheduler;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: small screen, PIPE_LAT=1, tick every 3 frames
  logic        rst_n, en, rdy;
  logic [15:0] gfx, pd, fc;
  logic [7:0]  px;
  logic [8:0]  py;
  logic        pw, fd, gt, bz;

  // renderer stand-in: colour encodes the address it was asked for
  assign gfx = {px, py[7:0]};

  pixel_scan_scheduler #(.WIDTH(W), .HEIGHT(H), .PIPE_LAT(1), .FRAMES_PER_TICK(3)) dut_a (
    .clock(clk), .reset_n(rst_n), .enable(en), .pixel_ready(rdy), .graphics_rgb(gfx),
    .pixel_x(px), .pixel_y(py), .pixel_data(pd), .pixel_write(pw), .frame_done(fd),
    .game_tick(gt), .frame_count(fc), .busy(bz));

  // DUT B: PIPE_LAT=3 capture timing
  logic        rst_b, en_b, rdy_b;
  logic [15:0] gfx_b, pd_b, fc_b;
  logic [7:0]  px_b;
  logic [8:0]  py_b;
  logic        pw_b, fd_b, gt_b, bz_b;

  pixel_scan_scheduler #(.WIDTH(2), .HEIGHT(2), .PIPE_LAT(3), .FRAMES_PER_TICK(1)) dut_b (
    .clock(clk), .reset_n(rst_b), .enable(en_b), .pixel_ready(rdy_b), .graphics_rgb(gfx_b),
    .pixel_x(px_b), .pixel_y(py_b), .pixel_data(pd_b), .pixel_write(pw_b), .frame_done(fd_b),
    .game_tick(gt_b), .frame_count(fc_b), .busy(bz_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned stall;
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] data;
  } vec_t;
  vec_t tbl [NPIX];

  // Reference model: raster pixel index, frames since reset, frame counter value
  int unsigned pidx = 0;
  int unsigned mon_frames = 0;
  logic [15:0] mon_count = '0;
  bit          pend = 0, prev_w = 0, prev_rdy = 0;
  logic [7:0]  prev_x;
  logic [8:0]  prev_y;
  logic [15:0] prev_d;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pidx = 0; pend = 0; mon_frames = 0; mon_count = '0; prev_w = 0;
    end else begin
      if (pend) begin
        mon_frames++;
        mon_count++;
        check("mon_frame_done", fd, 1);
        check("mon_frame_count", fc, mon_count);
        check("mon_game_tick", gt, (mon_frames % 3 == 0));
        pend = 0;
      end else begin
        check("mon_no_pulse", {fd, gt}, 0);
      end
      if (prev_w && !prev_rdy)
        check("mon_write_hold", {pw, px, py, pd}, {1'b1, prev_x, prev_y, prev_d});
      check("mon_write_outside_busy", pw & ~bz, 0);
      if (pidx != 0) check("mon_busy_midframe", bz, 1);
      if (pw && rdy) begin
        check("mon_pixel", {px, py, pd},
              {8'(pidx % W), 9'(pidx / W), 8'(pidx % W), 8'(pidx / W)});
        pidx++;
        if (pidx == NPIX) begin
          pidx = 0;
          pend = 1;
        end
      end
      prev_w = pw; prev_rdy = rdy; prev_x = px; prev_y = py; prev_d = pd;
    end
  end

  initial begin
    #1000000;
    check("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int unsigned got, k, nw, nf, ntick, nw2, nb;
    bit          found, seen;
    logic [7:0]  hx, lx;
    logic [8:0]  hy, ly;
    logic [15:0] hd, last_g;

    for (int i = 0; i < NPIX; i++) begin
      tbl[i].stall = (i == 6) ? 5 : 0;
      tbl[i].x     = 8'(i % W);
      tbl[i].y     = 9'(i / W);
      tbl[i].data  = {8'(i % W), 8'(i / W)};
    end

    rst_n = 0; en = 0; rdy = 0;
    rst_b = 0; en_b = 0; rdy_b = 0; gfx_b = '0;
    repeat (3) @(negedge clk);
    check("rst_write", pw, 0);
    check("rst_pulses", {fd, gt}, 0);
    check("rst_busy", bz, 0);
    check("rst_addr", {px, py}, 0);
    check("rst_data", pd, 0);
    check("rst_count", fc, 0);

    // Frame 1: ready tied high, writes in raster order, frame_done timing
    rst_n = 1; en = 1; rdy = 1;
    got = 0; k = 0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (pw) begin
        if (k < NPIX) check("f1_pixel", {px, py, pd}, {tbl[k].x, tbl[k].y, tbl[k].data});
        k++;
      end
      if (fd) begin
        got = t;
        break;
      end
    end
    check("f1_write_count", k, NPIX);
    check("f1_done_cycle", got, 25);
    check("f1_frame_count", fc, 1);

    // Frame 2: per-pixel handshake from the table, 5-cycle stall on (2,1)
    rdy = 0;
    for (int i = 0; i < NPIX; i++) begin
      found = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (pw) begin
          found = 1;
          break;
        end
      end
      check("f2_write_seen", found, 1);
      hx = px; hy = py; hd = pd;
      for (int s = 0; s < tbl[i].stall; s++) begin
        @(negedge clk);
        check("f2_stall_hold", {pw, px, py, pd}, {1'b1, hx, hy, hd});
      end
      check("f2_pixel", {px, py, pd}, {tbl[i].x, tbl[i].y, tbl[i].data});
      rdy = 1;
      @(negedge clk);
      rdy = 0;
      check("f2_single_transfer", pw, 0);
    end
    check("f2_frame_count", fc, 2);

    // Frames 3..7: game_tick only with frames 3 and 6
    rdy = 1; nf = 2; ntick = 0;
    for (int t = 0; t < 200 && nf < 7; t++) begin
      @(negedge clk);
      if (fd) begin
        nf++;
        check("tick_at_frame", gt, (nf % 3 == 0));
      end
      if (gt) ntick++;
    end
    check("frames_3_to_7", nf, 7);
    check("tick_total", ntick, 2);

    // Enable dropped at (1,1): frame still completes, then idle
    found = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (pw && px == 8'd1 && py == 9'd1) begin
        found = 1;
        break;
      end
    end
    check("drop_found_1_1", found, 1);
    en = 0;
    nw = 0; seen = 0; lx = '0; ly = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (pw) begin
        nw++; lx = px; ly = py;
      end
      if (fd) begin
        seen = 1;
        break;
      end
    end
    check("drop_frame_done", seen, 1);
    check("drop_remaining_writes", nw, 6);
    check("drop_last_pixel", {lx, ly}, {8'd3, 9'd2});
    @(negedge clk);
    check("drop_idle_busy", bz, 0);
    nw2 = 0; nb = 0;
    repeat (10) begin
      @(negedge clk);
      nw2 += pw;
      nb  += bz;
    end
    check("idle_no_writes", nw2, 0);
    check("idle_not_busy", nb, 0);

    en = 1; rdy = 0; found = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (pw) begin
        found = 1;
        break;
      end
    end
    check("reenable_write", found, 1);
    check("reenable_origin", {px, py}, 0);

    // Reset while waiting in WRITE at (2,0) with ready low
    rdy = 1; found = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (pw && px == 8'd2) begin
        found = 1;
        break;
      end
    end
    rdy = 0;
    check("rst_mid_found", found, 1);
    @(negedge clk);
    check("rst_mid_waiting", {pw, px, py}, {1'b1, 8'd2, 9'd0});
    rst_n = 0;
    @(negedge clk);
    check("rst_mid_write", pw, 0);
    check("rst_mid_outputs", {px, py, pd, fc, fd, gt, bz}, 0);
    rst_n = 1; en = 1; rdy = 1; got = 0;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      if (pw) begin
        got = t;
        break;
      end
    end
    check("restart_latency", got, 2);
    check("restart_origin", {px, py}, 0);

    // frame_count wrap: preload 65535 while idle, then one frame
    seen = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (fd) begin
        seen = 1;
        break;
      end
    end
    check("wrap_prior_frame", {seen, fc}, {1'b1, 16'd1});
    en = 0;
    @(negedge clk);
    check("wrap_idle", bz, 0);
    force dut_a.frame_count = 16'hFFFF;
    mon_count = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_count;
    @(negedge clk);
    check("wrap_preload", fc, 16'hFFFF);
    en = 1; seen = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (fd) begin
        seen = 1;
        break;
      end
    end
    check("wrap_frame_done", seen, 1);
    check("wrap_count_zero", fc, 0);

    // PIPE_LAT=3: capture the colour present in the 3rd FETCH cycle
    rst_b = 1; en_b = 1; rdy_b = 0; gfx_b = 16'($urandom);
    last_g = '0;
    for (int p = 0; p < 3; p++) begin
      for (int f = 1; f <= 3; f++) begin
        @(negedge clk);
        check("b_fetch_no_write", pw_b, 0);
        gfx_b  = 16'($urandom);
        last_g = gfx_b;
        rdy_b  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("b_write", pw_b, 1);
      check("b_capture", pd_b, last_g);
      check("b_addr", {px_b, py_b}, {8'(p % 2), 9'(p / 2)});
      gfx_b = 16'($urandom);
      rdy_b = 1;
    end

    // Randomized ready/enable/reset traffic against the reference model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rdy   = ($urandom_range(0, 9) < 6);
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_scan_scheduler.md
# pixel_scan_scheduler

Controller that sequences the LT24 pixel-write datapath for the Pong display. It raster-scans the screen, presents each pixel address to the graphics renderer and waits a fixed lookup latency. It then captures the returned colour and holds a write request until the display driver's `pixelReady` accepts it. At frame boundaries it issues the game-logic tick, so ball and paddle state only changes between frames and never tears mid-frame.

## Interface
Parameters:
- `WIDTH`, 240, pixels per line (x range 0..WIDTH-1)
- `HEIGHT`, 320, lines per frame (y range 0..HEIGHT-1)
- `PIPE_LAT`, 1, graphics lookup latency in clocks; legal range 1..7
- `FRAMES_PER_TICK`, 1, completed frames per `game_tick` pulse; legal range 1..255

Ports:
- `clock` in 1: system clock, 50 MHz
- `reset_n` in 1: synchronous, active-low reset
- `enable` in 1: scanning permitted
- `pixel_ready` in 1: display driver accepts a pixel this cycle
- `graphics_rgb` in 16: RGB565 colour from the renderer for the current `pixel_x`/`pixel_y`
- `pixel_x` out 8: current x address
- `pixel_y` out 9: current y address
- `pixel_data` out 16: colour being written
- `pixel_write` out 1: write request
- `frame_done` out 1: one-cycle pulse when a frame completes
- `game_tick` out 1: one-cycle pulse that advances game logic
- `frame_count` out 16: completed frames, wraps modulo 2^16
- `busy` out 1: high in any state except IDLE

## Operation
States: IDLE, FETCH, WRITE, FRAME_END.

- Reset (`reset_n`=0 at a rising edge) clears all registers:
  - state=IDLE
  - all outputs 0
  - internal latency counter and tick divider 0
- Reset applies in any state, including mid-handshake. `pixel_write` is low on the cycle after the reset edge.
- IDLE:
  - `enable`=1 → FETCH with x=0, y=0.
  - Otherwise remain in IDLE.
- FETCH:
  - Address is held stable.
  - Stay PIPE_LAT cycles. On the last one, register `graphics_rgb` into `pixel_data` → WRITE.
- WRITE:
  - `pixel_write`=1 and `pixel_data` held constant.
  - A transfer happens on any cycle with `pixel_write` & `pixel_ready`.
  - `pixel_ready`=0 → remain in WRITE indefinitely; there is no timeout.
  - On transfer, if x<WIDTH-1: x←x+1 → FETCH.
  - On transfer, if x==WIDTH-1 and y<HEIGHT-1: x←0, y←y+1 → FETCH.
  - On transfer, if x==WIDTH-1 and y==HEIGHT-1: x←0, y←0 → FRAME_END.
- FRAME_END (exactly one cycle):
  - `frame_done`=1.
  - `frame_count`←`frame_count`+1, wrapping to 0 after 65535.
  - Tick divider: if divider==FRAMES_PER_TICK-1, then `game_tick`=1 and divider←0; else divider←divider+1.
  - Next state: FETCH if `enable`=1, else IDLE.
- `enable` is sampled only in IDLE and FRAME_END. Dropping it mid-frame completes the current frame; frames are atomic.
- `pixel_ready` is ignored outside WRITE. No write is ever issued outside WRITE.
- `game_tick` is never asserted while a frame is in progress.

## Timing
- `pixel_write` is a registered Moore output.
  - It rises on the edge entering WRITE.
  - It falls on the edge after the transfer cycle.
  - It never deasserts without a transfer, except on reset.
- `pixel_x`/`pixel_y` change only on the edge following a transfer.
- `graphics_rgb` is sampled exactly PIPE_LAT cycles after the address becomes valid, on the final FETCH cycle.
- Per-pixel cost with `pixel_ready` tied high: PIPE_LAT+1 cycles.
- Frame period with ready tied high: WIDTH·HEIGHT·(PIPE_LAT+1)+1 cycles.
- Start-up: IDLE with `enable`=1 at edge n gives FETCH from cycle n+1 and the first `pixel_write` at cycle n+1+PIPE_LAT.
- `frame_done` and `game_tick` coincide in the same cycle when a tick is due.

## Test plan
- Use WIDTH=4, HEIGHT=3, PIPE_LAT=1, `pixel_ready`=1, `graphics_rgb`={x,y} encoded.
  - Required: 12 writes in order (0,0),(1,0)…(3,2), each with matching `pixel_data`.
  - Required: `frame_done` exactly 25 cycles after the first FETCH, and `frame_count`=1.
- Hold `pixel_ready`=0 for 5 cycles during WRITE of (2,1).
  - Required: `pixel_write`, `pixel_data`, `pixel_x`=2 and `pixel_y`=1 all stable.
  - Required: exactly one transfer when ready rises.
- FRAMES_PER_TICK=3, 7 frames.
  - Required: `game_tick` at frames 3 and 6 only, each coincident with `frame_done`.
- Deassert `enable` at pixel (1,1).
  - Required: frame completes to (3,2), then FRAME_END → IDLE.
  - Required: `busy`=0 and no further writes.
  - Required: re-enable restarts at (0,0).
- Assert `reset_n`=0 during WRITE with ready low.
  - Required: next cycle all outputs 0 and state IDLE.
  - Required: after release with `enable`=1, scan restarts at (0,0).
- Preload `frame_count`=65535 by running frames or forcing it, then complete one frame.
  - Required: `frame_count`=0.
- Use PIPE_LAT=3 and change `graphics_rgb` every cycle.
  - Required: the captured value equals the one present on the 3rd FETCH cycle.
